// File: rtl/complete_arbiter_pkg.sv
// Shared types and helpers for the completion broadcast arbiter.
// The completion record is the unit that moves from a pipe onto the broadcast.
package complete_arbiter_pkg;

    localparam int unsigned CA_SEQ_NUM_BITS = 32'd8;

    typedef struct packed {
        logic [CA_SEQ_NUM_BITS-1:0] seq_num;
        logic [4:0]                 waddr;
        logic [31:0]                wdata;
        logic                       wen;
    } completion_t;

    // Pointer width for an n-way arbiter; a single requester still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/complete_arbiter_if.sv
// Pipe-side request bundle and the shared completion broadcast.
interface complete_arbiter_if
    import complete_arbiter_pkg::*;
#(
    parameter int unsigned p_num_pipes    = 32'd2,
    parameter int unsigned p_seq_num_bits = CA_SEQ_NUM_BITS
);
    logic [p_num_pipes-1:0]                req_val;
    logic [p_num_pipes-1:0]                req_rdy;
    logic [p_num_pipes*p_seq_num_bits-1:0] req_seq_num;
    logic [p_num_pipes*5-1:0]              req_waddr;
    logic [p_num_pipes*32-1:0]             req_wdata;
    logic [p_num_pipes-1:0]                req_wen;
    logic                                  complete_val;
    logic [p_seq_num_bits-1:0]             complete_seq_num;
    logic [4:0]                            complete_waddr;
    logic [31:0]                           complete_wdata;
    logic                                  complete_wen;

    modport master (
        output req_val, req_seq_num, req_waddr, req_wdata, req_wen,
        input  req_rdy,
        input  complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen
    );

    modport slave (
        input  req_val, req_seq_num, req_waddr, req_wdata, req_wen,
        output req_rdy,
        output complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen
    );
endinterface

// File: rtl/complete_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the priority pointer.
// Reusable for any shared single-port resource.
module rr_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int unsigned p_num_pipes = 32'd2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [p_num_pipes-1:0] req_i,
    input  logic                   adv_i,
    output logic [p_num_pipes-1:0] gnt_o
);
    localparam int unsigned PTR_W = ptr_width(p_num_pipes);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx_s;
    logic [PTR_W-1:0] nxt_s;
    logic             found_s;

    // Grant search from ptr with wrap; pointer advances past the winner only on a transfer.
    always_comb begin
        gnt_o   = '0;
        nxt_s   = ptr_q;
        found_s = 1'b0;
        idx_s   = '0;
        for (int unsigned off = 0; off < p_num_pipes; off++) begin
            idx_s = PTR_W'((32'(ptr_q) + off) % p_num_pipes);
            if (req_i[idx_s] && !found_s) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
                nxt_s        = PTR_W'((32'(idx_s) + 32'd1) % p_num_pipes);
            end else begin
                found_s = found_s;
            end
        end
        if (!rst) begin
            gnt_o = '0;
        end else begin
            gnt_o = gnt_o;
        end
        if (adv_i) begin
            ptr_d = nxt_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/complete_arbiter.sv
// Arbitrates per-pipe completions onto the single registered regfile/completion broadcast.
// Writes to x0 are stripped of their write enable here so consumers need not check.
module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int unsigned p_num_pipes    = 32'd2,
    parameter int unsigned p_seq_num_bits = CA_SEQ_NUM_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    complete_arbiter_if.slave        bus
);
    completion_t            pkt_s [p_num_pipes];
    completion_t            win_s;
    completion_t            comp_d;
    completion_t            comp_q;
    logic                   val_d;
    logic                   val_q;
    logic                   xfer_s;
    logic [p_num_pipes-1:0] gnt_s;

    rr_arbiter #(
        .p_num_pipes (p_num_pipes)
    ) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (bus.req_val),
        .adv_i (xfer_s),
        .gnt_o (gnt_s)
    );

    // Unpack the flat per-pipe buses, select the winner and form the next broadcast.
    always_comb begin
        win_s = '0;
        for (int i = 0; i < int'(p_num_pipes); i++) begin
            pkt_s[i].seq_num = CA_SEQ_NUM_BITS'(bus.req_seq_num[i*p_seq_num_bits +: p_seq_num_bits]);
            pkt_s[i].waddr   = bus.req_waddr[i*5 +: 5];
            pkt_s[i].wdata   = bus.req_wdata[i*32 +: 32];
            pkt_s[i].wen     = bus.req_wen[i];
            if (gnt_s[i]) begin
                win_s = pkt_s[i];
            end else begin
                win_s = win_s;
            end
        end
        xfer_s = |(bus.req_val & gnt_s);
        val_d  = xfer_s;
        comp_d = comp_q;
        if (xfer_s) begin
            comp_d     = win_s;
            comp_d.wen = win_s.wen & (win_s.waddr != 5'd0);
        end else begin
            comp_d.wen = 1'b0;
        end
    end

    // Broadcast register; data fields hold when idle, reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q  <= 1'b0;
            comp_q <= '0;
        end else begin
            val_q  <= val_d;
            comp_q <= comp_d;
        end
    end

    assign bus.req_rdy          = gnt_s;
    assign bus.complete_val     = val_q;
    assign bus.complete_seq_num = p_seq_num_bits'(comp_q.seq_num);
    assign bus.complete_waddr   = comp_q.waddr;
    assign bus.complete_wdata   = comp_q.wdata;
    assign bus.complete_wen     = comp_q.wen;
endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: a 3-pipe and a 2-pipe instance share clock and reset.
module tb_complete_arbiter;

    typedef struct {
        logic [7:0]  seq;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    complete_arbiter_if #(.p_num_pipes(3), .p_seq_num_bits(8)) if3 ();
    complete_arbiter_if #(.p_num_pipes(2), .p_seq_num_bits(8)) if2 ();

    complete_arbiter #(.p_num_pipes(3), .p_seq_num_bits(8)) dut3 (
        .clk (clk), .rst (rst), .bus (if3)
    );
    complete_arbiter #(.p_num_pipes(2), .p_seq_num_bits(8)) dut2 (
        .clk (clk), .rst (rst), .bus (if2)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q3 [$];
    exp_t q2 [$];

    logic [7:0]  pay_seq   [3];
    logic [4:0]  pay_waddr [3];
    logic [31:0] pay_wdata [3];
    logic        pay_wen   [3];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic set_pay(input int tag);
        for (int i = 0; i < 3; i++) begin
            pay_seq[i]   = 8'(tag * 4 + i);
            pay_waddr[i] = 5'(tag + i + 1);
            pay_wdata[i] = 32'hC0DE_0000 + 32'(tag * 16 + i);
            pay_wen[i]   = !((i == 1) && (tag % 2 == 1));
        end
    endtask

    function automatic exp_t mk_exp(input int i);
        exp_t e;
        e.seq   = pay_seq[i];
        e.waddr = pay_waddr[i];
        e.wdata = pay_wdata[i];
        e.wen   = pay_wen[i] & (pay_waddr[i] != 5'd0);
        return e;
    endfunction

    // One cycle: drive, check grants, enqueue expected broadcasts for the expected winners.
    task automatic step(input logic r, input logic [2:0] v3, input logic [2:0] e3,
                        input logic [1:0] v2, input logic [1:0] e2, input logic cv0);
        @(posedge clk);
        #1;
        if (cv0) begin
            chk("idle_val3", 64'(if3.complete_val), 64'd0);
            chk("idle_val2", 64'(if2.complete_val), 64'd0);
        end
        rst             = r;
        if3.req_val     = v3;
        if2.req_val     = v2;
        if3.req_seq_num = {pay_seq[2], pay_seq[1], pay_seq[0]};
        if3.req_waddr   = {pay_waddr[2], pay_waddr[1], pay_waddr[0]};
        if3.req_wdata   = {pay_wdata[2], pay_wdata[1], pay_wdata[0]};
        if3.req_wen     = {pay_wen[2], pay_wen[1], pay_wen[0]};
        if2.req_seq_num = {pay_seq[1], pay_seq[0]};
        if2.req_waddr   = {pay_waddr[1], pay_waddr[0]};
        if2.req_wdata   = {pay_wdata[1], pay_wdata[0]};
        if2.req_wen     = {pay_wen[1], pay_wen[0]};
        #1;
        chk("rdy3", 64'(if3.req_rdy), 64'(e3));
        chk("rdy2", 64'(if2.req_rdy), 64'(e2));
        for (int i = 0; i < 3; i++) if (e3[i]) q3.push_back(mk_exp(i));
        for (int i = 0; i < 2; i++) if (e2[i]) q2.push_back(mk_exp(i));
    endtask

    // Monitor for the 3-pipe broadcast.
    always @(negedge clk) begin
        if (if3.complete_val === 1'b1) begin
            if (q3.size() == 0) begin
                chk("unexpected_val3", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("seq3",   64'(if3.complete_seq_num), 64'(e.seq));
                chk("waddr3", 64'(if3.complete_waddr),   64'(e.waddr));
                chk("wdata3", 64'(if3.complete_wdata),   64'(e.wdata));
                chk("wen3",   64'(if3.complete_wen),     64'(e.wen));
            end
        end
    end

    // Monitor for the 2-pipe broadcast.
    always @(negedge clk) begin
        if (if2.complete_val === 1'b1) begin
            if (q2.size() == 0) begin
                chk("unexpected_val2", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("seq2",   64'(if2.complete_seq_num), 64'(e.seq));
                chk("waddr2", 64'(if2.complete_waddr),   64'(e.waddr));
                chk("wdata2", 64'(if2.complete_wdata),   64'(e.wdata));
                chk("wen2",   64'(if2.complete_wen),     64'(e.wen));
            end
        end
    end

    initial begin
        if3.req_val = '0; if3.req_seq_num = '0; if3.req_waddr = '0;
        if3.req_wdata = '0; if3.req_wen = '0;
        if2.req_val = '0; if2.req_seq_num = '0; if2.req_waddr = '0;
        if2.req_wdata = '0; if2.req_wen = '0;
        set_pay(1);

        // Reset held with every pipe requesting: no grants, no broadcast.
        step(1'b0, 3'b111, 3'b000, 2'b11, 2'b00, 1'b0);
        step(1'b0, 3'b111, 3'b000, 2'b11, 2'b00, 1'b1);
        step(1'b0, 3'b111, 3'b000, 2'b11, 2'b00, 1'b1);

        // Full contention: rotating grants starting at pipe 0.
        set_pay(2); step(1'b1, 3'b111, 3'b001, 2'b11, 2'b01, 1'b1);
        set_pay(3); step(1'b1, 3'b111, 3'b010, 2'b11, 2'b10, 1'b0);
        set_pay(4); step(1'b1, 3'b111, 3'b100, 2'b11, 2'b01, 1'b0);
        set_pay(5); step(1'b1, 3'b111, 3'b001, 2'b11, 2'b10, 1'b0);
        set_pay(6); step(1'b1, 3'b111, 3'b010, 2'b11, 2'b01, 1'b0);
        set_pay(7); step(1'b1, 3'b111, 3'b100, 2'b11, 2'b10, 1'b0);

        // Reset mid-stream, then order restarts at pipe 0.
        set_pay(8);  step(1'b0, 3'b111, 3'b000, 2'b11, 2'b00, 1'b0);
        set_pay(9);  step(1'b1, 3'b111, 3'b001, 2'b11, 2'b01, 1'b1);
        set_pay(10); step(1'b1, 3'b111, 3'b010, 2'b11, 2'b10, 1'b0);

        // Write to x0 keeps valid but drops wen.
        set_pay(11); pay_waddr[0] = 5'd0;
        step(1'b1, 3'b001, 3'b001, 2'b00, 2'b00, 1'b0);

        // Grant pipe 2, idle, then pointer has wrapped to 0 and held.
        set_pay(12); step(1'b1, 3'b100, 3'b100, 2'b00, 2'b00, 1'b0);
        step(1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
        step(1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
        step(1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
        step(1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);
        set_pay(13); step(1'b1, 3'b101, 3'b001, 2'b00, 2'b00, 1'b1);
        step(1'b1, 3'b101, 3'b100, 2'b00, 2'b00, 1'b0);

        // Two-pipe single requester on pipe 1.
        pay_seq[1] = 8'd5; pay_waddr[1] = 5'd3; pay_wdata[1] = 32'hDEADBEEF; pay_wen[1] = 1'b1;
        step(1'b1, 3'b000, 3'b000, 2'b10, 2'b10, 1'b0);
        step(1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b0);
        step(1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 1'b1);

        @(posedge clk);
        #1;
        chk("drain3", 64'(q3.size()), 64'd0);
        chk("drain2", 64'(q2.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
